pipelined_add_sub: RTL and testbench

PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

---
 rtl/pipelined_add_sub.sv | 134 +++++++++++++
 tb/tb_pipelined_add_sub.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// Chunked, pipelined adder/subtractor: STAGES ripple segments of N/STAGES bits with a
// global-stall valid/ready handshake and registered result flags.
module pipelined_add_sub #(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry_out,
  output logic         overflow,
  output logic         zero,
  output logic         negative,
  output logic         busy
);

  localparam int unsigned W  = (STAGES == 0) ? N : N / STAGES;
  localparam int unsigned W1 = W + 1;

  if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
    $error("pipelined_add_sub: illegal N/STAGES combination");
  end

  logic              advance;
  logic [STAGES-1:0] v_vec;
  logic [N-1:0]      b_eff;

  assign b_eff = B ^ {N{sub}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * W;
    localparam int unsigned HI = LO + W;

    // Operand bits still to be summed by this and later stages
    logic [N-1:LO] a_in;
    logic [N-1:LO] b_in;
    logic          c_in;
    logic          z_in;
    logic          v_in;
    logic [W1-1:0] add_c;
    logic [HI-1:0] s_d;
    logic          z_d;

    logic          v_q;
    logic          c_q;
    logic          z_q;
    logic [HI-1:0] s_q;

    if (k == 0) begin : g_head
      assign a_in = A;
      assign b_in = b_eff;
      assign c_in = sub;
      assign z_in = 1'b1;
      assign v_in = in_valid;
      assign s_d  = add_c[W-1:0];
    end else begin : g_tail
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign z_in = g_stage[k-1].z_q;
      assign v_in = g_stage[k-1].v_q;
      assign s_d  = {add_c[W-1:0], g_stage[k-1].s_q};
    end

    assign add_c = W1'(a_in[HI-1:LO]) + W1'(b_in[HI-1:LO]) + W1'(c_in);
    assign z_d   = z_in & (add_c[W-1:0] == '0);

    // Payload only loads for valid operations so bubbles leave data untouched
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        z_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= add_c[W];
          z_q <= z_d;
          s_q <= s_d;
        end
      end
    end

    assign v_vec[k] = v_q;

    if (k < STAGES - 1) begin : g_fwd
      logic [N-1:HI] a_q;
      logic [N-1:HI] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && v_in) begin
          a_q <= a_in[N-1:HI];
          b_q <= b_in[N-1:HI];
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB equals a^b^sum at that bit
      assign ovf_d = a_in[N-1] ^ b_in[N-1] ^ add_c[W-1] ^ add_c[W];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance && v_in) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = v_vec[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign busy      = |v_vec;
  assign sum       = g_stage[STAGES-1].s_q;
  assign carry_out = g_stage[STAGES-1].c_q;
  assign zero      = g_stage[STAGES-1].z_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;
  assign negative  = sum[N-1];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Randomized self-checking bench for pipelined_add_sub (N=32, STAGES=4) against an
// arithmetic reference model with a cycle-level slot model of the handshake.
module tb_pipelined_add_sub;

  localparam int unsigned N = 32;
  localparam int unsigned L = 4;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         o;
    logic         z;
    logic         n;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic         busy;

  int   n_checks;
  int   n_errors;
  logic [L-1:0] mv;
  res_t mr [L];

  pipelined_add_sub #(.N(N), .STAGES(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero),
    .negative(negative), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result from plain two's-complement arithmetic
  function automatic res_t ref_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    res_t r;
    logic [N:0] full;
    longint sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = s ? (sa - sb) : (sa + sb);
    if (s) full = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
    else   full = {1'b0, a} + {1'b0, b};
    r.s = full[N-1:0];
    r.c = full[N];
    r.o = (sr > longint'(32'sh7FFFFFFF)) || (sr < -longint'(64'h80000000));
    r.z = (r.s == '0);
    r.n = r.s[N-1];
    return r;
  endfunction

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return N'($urandom);
    endcase
  endfunction

  // One cycle: drive mid-low phase, check against the slot model, advance the model
  task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic s, input logic ordy);
    logic adv;
    @(negedge clk);
    in_valid  = v;
    A         = a;
    B         = b;
    sub       = s;
    out_ready = ordy;
    #1;
    adv = !mv[L-1] || ordy;
    check("out_valid", 64'(out_valid), 64'(mv[L-1]));
    check("busy", 64'(busy), 64'(|mv));
    check("in_ready", 64'(in_ready), 64'(adv));
    if (mv[L-1]) begin
      check("sum", 64'(sum), 64'(mr[L-1].s));
      check("carry_out", 64'(carry_out), 64'(mr[L-1].c));
      check("overflow", 64'(overflow), 64'(mr[L-1].o));
      check("zero", 64'(zero), 64'(mr[L-1].z));
      check("negative", 64'(negative), 64'(mr[L-1].n));
    end
    if (adv) begin
      for (int i = L - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mr[i] = mr[i-1];
      end
      mv[0] = v;
      mr[0] = ref_op(a, b, s);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    mv = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    mv        = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_flags", 64'({carry_out, overflow, zero, negative}), 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Corner vectors followed by more back-to-back operations (8 in a row)
    step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, pick(), pick(), 1'($urandom), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, N'($urandom), N'($urandom), 1'($urandom), 1'b1);

    // Consumer stall with a result pending and new operations offered
    for (int i = 0; i < 4; i++) step(1'b1, pick(), pick(), 1'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, pick(), pick(), 1'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Reset with three operations in flight, then accept right after release
    for (int i = 0; i < 3; i++) step(1'b1, pick(), pick(), 1'($urandom), 1'b1);
    reset_pulse();
    step(1'b1, 32'h1234_5678, 32'h0000_0008, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Random traffic with random back-pressure and bubbles
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 7), pick(), pick(), 1'($urandom),
           1'($urandom_range(0, 9) < 6));
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
